register_load_arbiter: RTL and testbench
========================================

# register_load_arbiter

Shares one parallel-load register between four requesters. Each requester raises a request with its data word; the arbiter picks one winner per transaction and captures that winner's data. It drives the register's `load`/`D` inputs for exactly one cycle, then completes a four-phase req/ack handshake with the winner. It sits directly in front of the parallel-output register and is the only block allowed to drive that register's `load` and `D` inputs.

## Interface
- `WIDTH`, default 3: data width; must match the register's data width.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `req`  input  4  request lines; bit i belongs to requester i.
- `data0`..`data3`  input  WIDTH each  data word offered by requester i; it only needs to be valid in the cycle its request wins.
- `ack`  output  4  acknowledge to requester i; one-hot or all-zero.
- `load`  output  1  load strobe to the register.
- `D`  output  WIDTH  data to the register.
- `owner`  output  2  index of the current or most recent winner.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
The arbiter is a three-state machine: IDLE, LOAD, ACK.

**IDLE**
- `load` = 0 and `ack` = 0.
- If `req` is nonzero at the clock edge:
  - select a winner using the priority pointer `ptr`;
  - latch `owner` with the winner's index;
  - latch `D` with the winner's data word;
  - go to LOAD.
- If `req` is zero, stay in IDLE.

**LOAD**
- `load` = 1 for exactly this one cycle.
- Always go to ACK on the next edge.

**ACK**
- `ack[owner]` = 1; all other `ack` bits are 0.
- When `req[owner]` is sampled low:
  - go to IDLE;
  - set `ptr` to (`owner` + 1) mod 4.
- If `req[owner]` stays high, stay in ACK indefinitely.

**Round-robin selection**
- The search starts at index `ptr` and moves upward, wrapping mod 4.
- The first set `req` bit found is the winner.
- After reset, `ptr` = 0, so the priority order is 0, 1, 2, 3.

**Capture rules**
- `D` and `owner` are registered and hold their values until the next grant.
- Changes to `data*` after the grant are ignored.
- If the winner drops `req` during LOAD, the transaction still completes: `load` fires, then `ack` is high for one cycle, and the arbiter returns to IDLE.
- Requests from non-winners are ignored until the arbiter is back in IDLE. They are never lost as long as they are held high.
- A requester must not re-raise `req` until its `ack` has dropped.

**Reset**
- On reset, whether idle or mid-transaction, on the next edge:
  - state = IDLE;
  - `load` = 0, `ack` = 0;
  - `D` = 0, `owner` = 0, `ptr` = 0;
  - `busy` = 0.
- A pulse in progress is cut immediately. No `load` pulse is emitted after reset.

## Timing
- Request to load: `req` is sampled high at edge E0. `load` is high from E0 to E1, and the register captures `D` at E1. That is a latency of 1 cycle.
- `ack` rises at E1 and stays high while `req[owner]` is high.
- The `req[owner]` deassertion is sampled at edge Ek. `ack` falls at Ek, and the machine is in IDLE after Ek.
- A new grant can be made at Ek+1.
- Minimum transaction length is 3 cycles (IDLE, LOAD, ACK), so the maximum load rate is one load every 3 cycles.
- `D` is stable from the edge before `load` rises until the next grant.
- `busy` is registered and aligned with the state.

## Configuration
- Macro: `LOAD_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority. The search always starts at index 0, so requester 0 is highest. `ptr` is not implemented and does not update.
- **Undefined (default):** round-robin selection as described under Operation.
- The handshake, timing and reset behaviour are identical in both builds.

## Test plan
- **Reset mid-transaction:**
  - Stimulus: `rst` = 1 while the arbiter is in LOAD.
  - Required response: on the next edge, `load` = 0, `ack` = 0, `D` = 0, `owner` = 0, `busy` = 0. No later `load` pulse appears.
- **Single request:**
  - Stimulus: `req` = 4'b0100, `data2` = 3'b101.
  - Required response: one cycle later, `load` = 1 with `D` = 3'b101 and `owner` = 2. On the following edge, `ack` = 4'b0100. When `req` drops, `ack` = 0 and the arbiter is in IDLE.
- **Round-robin:**
  - Stimulus: `req` = 4'b1111 held, each requester releasing after its `ack`.
  - Required response: grants in order 0, 1, 2, 3, 0. Each grant is followed by exactly one `load` pulse.
- **Pointer wrap:**
  - Stimulus: after a grant to 3, `req` = 4'b0011.
  - Required response: the next grant goes to 0.
- **Withdrawal during LOAD:**
  - Stimulus: winner 1 drops `req` in the LOAD cycle.
  - Required response: `load` still pulses, `ack[1]` is high for exactly 1 cycle, then IDLE.
- **Fixed-priority build:**
  - Stimulus: with `LOAD_ARB_FIXED_PRIO_EN` defined, `req` = 4'b1010 held repeatedly.
  - Required response: requester 1 wins every transaction.

Source files
------------

// File: rtl/register_load_arbiter.sv
// register_load_arbiter
//   Shares one parallel-load register between four requesters. A winner is
//   picked per transaction, its data word is captured into D, load is pulsed
//   for one cycle, then a four-phase req/ack handshake completes with the
//   winner.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req[3:0]     request lines, bit i belongs to requester i
//   data0..data3 data word offered by each requester (WIDTH bits)
//   ack[3:0]     acknowledge, one-hot or zero
//   load         load strobe to the register
//   D            data to the register (WIDTH bits)
//   owner[1:0]   index of the current or most recent winner
//   busy         high whenever the machine is not idle
//
// Build option:
//   LOAD_ARB_FIXED_PRIO_EN  when defined, selection is fixed priority
//                           (requester 0 highest) and no rotating pointer
//                           exists; otherwise selection is round-robin.
//
// State table:
//   state | meaning
//   IDLE  | no transaction; next nonzero req is granted
//   LOAD  | load strobe high for this single cycle
//   ACK   | ack[owner] high until req[owner] drops

module register_load_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [3:0]       ack,
    output logic             load,
    output logic [WIDTH-1:0] D,
    output logic [1:0]       owner,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       start;
    logic [1:0]       cand;
    logic [1:0]       win_idx;
    logic [WIDTH-1:0] win_data;

`ifdef LOAD_ARB_FIXED_PRIO_EN
    assign start = 2'd0;
`else
    logic [1:0] ptr;
    assign start = ptr;
`endif

    // Scan from the farthest offset back to the start so the lowest offset
    // with a set request is the one left in win_idx.
    always_comb begin
        win_idx = start;
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        case (win_idx)
            2'd0:    win_data = data0;
            2'd1:    win_data = data1;
            2'd2:    win_data = data2;
            default: win_data = data3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            load  <= 1'b0;
            ack   <= 4'b0000;
            D     <= '0;
            owner <= 2'd0;
            busy  <= 1'b0;
`ifndef LOAD_ARB_FIXED_PRIO_EN
            ptr   <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    load <= 1'b0;
                    ack  <= 4'b0000;
                    if (|req) begin
                        owner <= win_idx;
                        D     <= win_data;
                        load  <= 1'b1;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // The handshake proceeds even if the winner already
                    // withdrew; ACK then exits after one cycle.
                    load  <= 1'b0;
                    ack   <= 4'b0001 << owner;
                    state <= ACK;
                end
                ACK: begin
                    if (!req[owner]) begin
                        ack   <= 4'b0000;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifndef LOAD_ARB_FIXED_PRIO_EN
                        ptr   <= owner + 2'd1;
`endif
                    end
                end
                default: begin
                    load  <= 1'b0;
                    ack   <= 4'b0000;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_load_arbiter.sv
// Directed bench for register_load_arbiter (WIDTH = 3). Inputs are driven
// and outputs sampled 1 time unit after each rising edge.

module tb_register_load_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [2:0] dat [4];
    logic [3:0] ack;
    logic       load;
    logic [2:0] D;
    logic [1:0] owner;
    logic       busy;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    register_load_arbiter #(.WIDTH(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data0 (dat[0]),
        .data1 (dat[1]),
        .data2 (dat[2]),
        .data3 (dat[3]),
        .ack   (ack),
        .load  (load),
        .D     (D),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: wait (bounded) for load, check the grant, check
    // the ack phase, release the request and check the return to idle.
    task automatic grant(input string tag, input int idx, input logic [2:0] exp_d,
                         input bit rearm);
        int n;
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << idx;
        n = 0;
        do begin
            tick();
            n++;
        end while (!load && n < 10);
        chk($sformatf("%s_load", tag), load, 1);
        chk($sformatf("%s_owner", tag), owner, idx);
        chk($sformatf("%s_D", tag), D, exp_d);
        tick();
        chk($sformatf("%s_one_pulse", tag), load, 0);
        chk($sformatf("%s_ack", tag), ack, exp_ack);
        req[idx] = 1'b0;
        tick();
        chk($sformatf("%s_ack_drop", tag), ack, 0);
        chk($sformatf("%s_idle", tag), busy, 0);
        if (rearm) req[idx] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) dat[i] = 3'd0;
        tick();
        tick();
        chk("rst_load", load, 0);
        chk("rst_ack", ack, 0);
        chk("rst_D", D, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Single request from requester 2.
        req    = 4'b0100;
        dat[2] = 3'b101;
        tick();
        chk("single_load", load, 1);
        chk("single_D", D, 3'b101);
        chk("single_owner", owner, 2);
        chk("single_busy", busy, 1);
        chk("single_ack_lo", ack, 0);
        dat[2] = 3'b010;
        tick();
        chk("single_load_end", load, 0);
        chk("single_ack", ack, 4'b0100);
        chk("single_D_hold", D, 3'b101);
        tick();
        chk("single_ack_held", ack, 4'b0100);
        req = 4'b0000;
        tick();
        chk("single_ack_drop", ack, 0);
        chk("single_idle", busy, 0);
        chk("single_owner_hold", owner, 2);
        chk("single_D_hold2", D, 3'b101);

        // Reset while in LOAD.
        req    = 4'b0001;
        dat[0] = 3'b011;
        tick();
        chk("midrst_in_load", load, 1);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        chk("midrst_load", load, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_D", D, 0);
        chk("midrst_owner", owner, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_load", load, 0);
        end

        dat[0] = 3'd1;
        dat[1] = 3'd2;
        dat[2] = 3'd3;
        dat[3] = 3'd4;

`ifndef LOAD_ARB_FIXED_PRIO_EN
        // Round-robin with everyone requesting; requester 0 re-raises after
        // its first ack so the sequence wraps back to it.
        req = 4'b1111;
        grant("rr0", 0, 3'd1, 1);
        grant("rr1", 1, 3'd2, 0);
        grant("rr2", 2, 3'd3, 0);
        grant("rr3", 3, 3'd4, 0);
        grant("rr0b", 0, 3'd1, 0);

        // Pointer wrap: after grant to 3, 0011 goes to 0; after grant to 1
        // the search from 2 wraps around to 0.
        req = 4'b1000;
        grant("wrap3", 3, 3'd4, 0);
        req = 4'b0011;
        grant("wrap0", 0, 3'd1, 0);
        grant("wrap1", 1, 3'd2, 0);
        req = 4'b0011;
        grant("wrap0b", 0, 3'd1, 0);
        grant("wrap1b", 1, 3'd2, 0);
`else
        req = 4'b1111;
        grant("fp0", 0, 3'd1, 0);
        grant("fp1", 1, 3'd2, 0);
        grant("fp2", 2, 3'd3, 0);
        grant("fp3", 3, 3'd4, 0);
`endif

        // Winner 1 withdraws during LOAD.
        req    = 4'b0010;
        dat[1] = 3'b110;
        tick();
        chk("wd_load", load, 1);
        chk("wd_owner", owner, 1);
        req = 4'b0000;
        tick();
        chk("wd_ack", ack, 4'b0010);
        tick();
        chk("wd_ack_drop", ack, 0);
        chk("wd_idle", busy, 0);
        tick();
        chk("wd_no_load", load, 0);

        // 1010 held repeatedly.
        req = 4'b1010;
`ifdef LOAD_ARB_FIXED_PRIO_EN
        grant("hold1a", 1, 3'b110, 1);
        grant("hold1b", 1, 3'b110, 1);
        grant("hold1c", 1, 3'b110, 0);
        grant("hold3", 3, 3'd4, 0);
`else
        grant("hold3a", 3, 3'd4, 1);
        grant("hold1a", 1, 3'b110, 1);
        grant("hold3b", 3, 3'd4, 0);
        grant("hold1b", 1, 3'b110, 0);
`endif
        tick();
        chk("end_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
